timer_controller: RTL and testbench

TIMER_CONTROLLER -- requirements
Module: timer_controller

---
 rtl/timer_controller_if.sv | 22 ++
 rtl/timer_controller.sv | 141 ++++++++++++++
 tb/tb_timer_controller.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_controller_if.sv
// Button and display bundle for the countdown timer: the bench or front panel
// drives the buttons (master) and the timer core drives the readouts (slave).
interface timer_controller_if;
  logic        btn_inc;
  logic        minute_sel;
  logic        btn_start;
  logic        btn_clear;
  logic [21:0] preset;
  logic [21:0] remaining;
  logic [1:0]  state;
  logic        done;

  modport master (
    output btn_inc, minute_sel, btn_start, btn_clear,
    input  preset, remaining, state, done
  );

  modport slave (
    input  btn_inc, minute_sel, btn_start, btn_clear,
    output preset, remaining, state, done
  );
endinterface

// File: rtl/timer_controller.sv
// Programmable millisecond countdown timer: debounced-edge buttons set a preset,
// then a prescaled countdown runs, pauses, resumes and signals completion.
module timer_controller #(
  parameter int CLK_PER_MS = 100000,
  parameter int MAX_MS     = 3599000
) (
  input logic               clk,
  input logic               rst_n,
  timer_controller_if.slave bus
);
  typedef enum logic [1:0] {
    PROG  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam int              PW         = $clog2(CLK_PER_MS);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_PER_MS - 1);
  localparam logic [22:0]     MAX_SUM    = 23'(MAX_MS);
  localparam logic [22:0]     STEP_MIN   = 23'd60000;
  localparam logic [22:0]     STEP_SEC   = 23'd1000;

  // Buttons packed as {clear, start, inc}.
  logic [2:0] btn_raw, sync_a, sync_b, btn_prev, pulse;
  logic       clr_p, start_p, inc_p;

  assign btn_raw = {bus.btn_clear, bus.btn_start, bus.btn_inc};

  // NOTE: every flop, synchronizers included, has an async reset so a button
  // held through reset is seen as a fresh rising edge once reset lifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a   <= '0;
      sync_b   <= '0;
      btn_prev <= '0;
    end else begin
      // NOTE: non-blocking assignments let each stage capture the previous
      // stage's pre-edge value, forming a true shift chain.
      sync_a   <= btn_raw;
      sync_b   <= sync_a;
      btn_prev <= sync_b;
    end
  end

  assign pulse = sync_b & ~btn_prev;
  assign {clr_p, start_p, inc_p} = pulse;

  state_t          state_q, state_d;
  logic [21:0]     preset_q, preset_d;
  logic [21:0]     remaining_q, remaining_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [22:0]     inc_sum;
  logic [21:0]     inc_sat;
  logic            tick;

  assign inc_sum = {1'b0, preset_q} + (bus.minute_sel ? STEP_MIN : STEP_SEC);
  assign inc_sat = (inc_sum > MAX_SUM) ? MAX_SUM[21:0] : inc_sum[21:0];
  assign tick    = (presc_q == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PROG;
      preset_q    <= '0;
      remaining_q <= '0;
      presc_q     <= '0;
    end else begin
      state_q     <= state_d;
      preset_q    <= preset_d;
      remaining_q <= remaining_d;
      presc_q     <= presc_d;
    end
  end

  always_comb begin
    // NOTE: hold-by-default on every target keeps this block free of latches.
    state_d     = state_q;
    preset_d    = preset_q;
    remaining_d = remaining_q;
    presc_d     = presc_q;

    unique case (state_q)
      PROG: begin
        if (clr_p) begin
          preset_d    = '0;
          remaining_d = '0;
        end else if (start_p) begin
          if (preset_q != '0) begin
            state_d     = RUN;
            presc_d     = '0;
            remaining_d = preset_q;
          end
        end else if (inc_p) begin
          preset_d    = inc_sat;
          remaining_d = inc_sat;
        end
      end

      RUN: begin
        if (clr_p) begin
          state_d     = PROG;
          remaining_d = preset_q;
          presc_d     = '0;
        end else if (start_p) begin
          // A start on the terminal edge still wins; the pending tick is kept.
          state_d = PAUSE;
        end else if (tick) begin
          presc_d = '0;
          if (remaining_q != '0) remaining_d = remaining_q - 22'd1;
          if (remaining_q <= 22'd1) state_d = DONE;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end

      PAUSE: begin
        if (clr_p) begin
          state_d     = PROG;
          remaining_d = preset_q;
          presc_d     = '0;
        end else if (start_p) begin
          state_d = RUN;
        end
      end

      DONE: begin
        if (clr_p || start_p) begin
          state_d     = PROG;
          remaining_d = preset_q;
        end
      end

      default: state_d = PROG;
    endcase
  end

  assign bus.preset    = preset_q;
  assign bus.remaining = remaining_q;
  assign bus.state     = state_q;
  assign bus.done      = (state_q == DONE);
endmodule

// File: tb/tb_timer_controller.sv
// Randomized scoreboard bench for timer_controller: a millisecond-level model
// predicts every output change with its clock edge; a monitor compares them.
module tb_timer_controller;
  localparam int N   = 4;
  localparam int MAX = 3599000;
  localparam int S_PROG = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  timer_controller_if bus ();

  timer_controller #(.CLK_PER_MS(N), .MAX_MS(MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int    cyc;
    int    preset;
    int    rem;
    int    st;
    int    done;
    string tag;
  } exp_t;
  exp_t q[$];

  // Reference model: state, values, and clocks spent in RUN since the last tick.
  int m_state, m_preset, m_rem, m_phase, m_time;
  bit mon_en = 1'b0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(int c, string tag);
    q.push_back('{c, m_preset, m_rem, m_state, (m_state == S_DONE) ? 1 : 0, tag});
  endtask

  // Jump the model forward to edge t, emitting one event per millisecond tick.
  task automatic advance_to(int t);
    int nt;
    while (m_state == S_RUN && (m_time + (N - m_phase)) <= t) begin
      nt      = m_time + (N - m_phase);
      m_time  = nt;
      m_phase = 0;
      m_rem   = m_rem - 1;
      if (m_rem == 0) m_state = S_DONE;
      push(nt, "tick");
    end
    if (t > m_time) begin
      if (m_state == S_RUN) m_phase = m_phase + (t - m_time);
      m_time = t;
    end
  endtask

  // Effect of button pulses acting on edge c.
  task automatic apply(int c, bit clr, bit st, bit inc, bit msel);
    int op, orm, os, sum;
    advance_to(c - 1);
    if (!(m_state == S_RUN && (clr || st))) advance_to(c);
    m_time = c;
    op = m_preset; orm = m_rem; os = m_state;
    case (m_state)
      S_PROG: begin
        if (clr) begin
          m_preset = 0; m_rem = 0;
        end else if (st) begin
          if (m_preset > 0) begin
            m_state = S_RUN; m_phase = 0; m_rem = m_preset;
          end
        end else if (inc) begin
          sum = m_preset + (msel ? 60000 : 1000);
          if (sum > MAX) sum = MAX;
          m_preset = sum; m_rem = sum;
        end
      end
      S_RUN, S_PAUSE: begin
        if (clr) begin
          m_state = S_PROG; m_rem = m_preset; m_phase = 0;
        end else if (st) begin
          m_state = (m_state == S_RUN) ? S_PAUSE : S_RUN;
        end
      end
      default: begin
        if (clr || st) begin
          m_state = S_PROG; m_rem = m_preset;
        end
      end
    endcase
    if (op != m_preset || orm != m_rem || os != m_state) push(c, "press");
  endtask

  task automatic step();
    @(negedge clk);
    advance_to(cyc + 2);
  endtask

  task automatic press(bit clr, bit st, bit inc, bit msel, int hold);
    bus.minute_sel = msel;
    bus.btn_clear  = clr;
    bus.btn_start  = st;
    bus.btn_inc    = inc;
    apply(cyc + 3, clr, st, inc, msel);
    repeat (hold) step();
    bus.btn_clear = 1'b0;
    bus.btn_start = 1'b0;
    bus.btn_inc   = 1'b0;
    repeat (2) step();
  endtask

  task automatic snap(string tag);
    advance_to(cyc + 2);
    push(cyc + 2, tag);
  endtask

  task automatic do_reset(bit held, bit msel);
    mon_en = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_preset",    int'(bus.preset),    0);
    check("rst_remaining", int'(bus.remaining), 0);
    check("rst_state",     int'(bus.state),     0);
    check("rst_done",      int'(bus.done),      0);
    q.delete();
    m_state = S_PROG; m_preset = 0; m_rem = 0; m_phase = 0;
    bus.btn_inc    = held;
    bus.btn_start  = 1'b0;
    bus.btn_clear  = 1'b0;
    bus.minute_sel = msel;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    m_time = cyc;
    if (held) apply(cyc + 3, 1'b0, 1'b0, 1'b1, msel);
    mon_en = 1'b1;
    repeat (3) step();
    bus.btn_inc = 1'b0;
    repeat (2) step();
  endtask

  // Monitor: compares every predicted event on its edge, flags any other change.
  int   lp, lr, ls, ld, cp, cr, cs, cd;
  bit   matched;
  exp_t e;
  always @(negedge clk) begin
    cp = int'(bus.preset); cr = int'(bus.remaining);
    cs = int'(bus.state);  cd = int'(bus.done);
    if (rst_n && mon_en) begin
      matched = 1'b0;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++; failures++;
        $display("FAIL missed_%s: event due at cycle %0d not seen, now %0d", q[0].tag, q[0].cyc, cyc);
        void'(q.pop_front());
      end
      while (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        check({e.tag, "_preset"},    cp, e.preset);
        check({e.tag, "_remaining"}, cr, e.rem);
        check({e.tag, "_state"},     cs, e.st);
        check({e.tag, "_done"},      cd, e.done);
        matched = 1'b1;
      end
      if (!matched && (cp != lp || cr != lr || cs != ls || cd != ld)) begin
        checks++; failures++;
        $display("FAIL unexpected_change: cycle %0d preset=%0d remaining=%0d state=%0d done=%0d, required no change",
                 cyc, cp, cr, cs, cd);
      end
    end
    lp = cp; lr = cr; ls = cs; ld = cd;
  end

  int term;

  initial begin
    bus.btn_inc = 1'b0; bus.btn_start = 1'b0; bus.btn_clear = 1'b0; bus.minute_sel = 1'b0;
    do_reset(1'b0, 1'b0);
    snap("reset");

    // 2 minutes + 3 seconds
    press(0, 0, 1, 1, 2);
    press(0, 0, 1, 1, 4);
    for (int i = 0; i < 3; i++) press(0, 0, 1, 0, 1 + i);
    snap("preset_123000");

    press(1, 1, 1, 0, 2);
    snap("prio_clear");
    press(0, 1, 0, 0, 2);
    snap("start_zero");

    for (int i = 0; i < 61; i++) begin
      press(0, 0, 1, 1, 1);
      if (i >= 59) snap("saturate");
    end

    press(1, 0, 0, 0, 2);
    press(0, 0, 1, 0, 2);
    press(0, 1, 1, 0, 2);
    press(0, 0, 1, 1, 2);
    for (int k = 0; k < 6000 && m_state != S_DONE; k++) step();
    repeat (3) step();
    snap("done");
    press(0, 0, 1, 0, 2);
    press(0, 1, 0, 0, 2);
    snap("done_to_prog");

    press(0, 1, 0, 0, 2);
    for (int k = 0; k < 6000 && m_rem > 500; k++) step();
    press(0, 1, 0, 0, 3);
    repeat (200) step();
    snap("paused");
    press(0, 0, 1, 0, 2);
    press(0, 1, 0, 0, 2);
    repeat (37) step();
    snap("resumed");
    press(1, 0, 0, 0, 2);
    snap("clear_run");

    // Start lands on the same edge as the terminal tick.
    press(0, 1, 0, 0, 2);
    term = m_time + (N - m_phase) + (m_rem - 1) * N;
    while (cyc + 3 < term) step();
    press(0, 1, 0, 0, 2);
    snap("term_pause");
    press(0, 1, 0, 0, 2);
    repeat (4) step();
    snap("term_resume");
    press(1, 0, 0, 0, 2);

    for (int i = 0; i < 40; i++) begin
      bit rc, rs, ri, rm;
      rc = ($urandom_range(0, 5) == 0);
      rs = ($urandom_range(0, 2) == 0);
      ri = ($urandom_range(0, 1) == 1);
      rm = ($urandom_range(0, 7) == 0);
      if (rc || rs || ri) press(rc, rs, ri, rm, $urandom_range(1, 6));
      repeat ($urandom_range(0, 30)) step();
      if (i % 10 == 9) snap("random");
    end

    // Asynchronous reset mid-RUN, button held across release.
    press(1, 0, 0, 0, 2);
    press(0, 0, 1, 0, 2);
    press(0, 1, 0, 0, 2);
    repeat (13) step();
    do_reset(1'b1, 1'b0);
    snap("post_reset_held");

    for (int k = 0; k < 200 && q.size() > 0; k++) step();
    if (q.size() > 0) begin
      checks++; failures++;
      $display("FAIL drain: %0d predicted events still pending, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
